if_id_skid: RTL and testbench
=============================

# if_id_skid

Parametrised fetch/decode boundary register with a valid/ready handshake and a two-entry skid buffer. It replaces the single freeze-controlled register between fetch and decode. When decode stalls, it absorbs one in-flight fetch without combinational backpressure. On a taken branch it flushes both entries and presents a NOP. A saturating counter records decode-stall cycles for performance analysis.

## Interface
Parameters:
- PC_W, 16, width of both PC fields
- IR_W, 16, instruction width
- NOP, {IR_W{1'b0}}, instruction word presented when no valid entry or after a flush
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- flush  in  1  taken branch; discard all held and incoming entries
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  block can accept an entry this cycle
- in_pc, in_pc2  in  PC_W  PC and PC+2 from fetch
- in_ir  in  IR_W  fetched instruction
- out_valid  out  1  decode-side entry valid
- out_ready  in  1  decode consumes the entry this cycle
- out_pc, out_pc2  out  PC_W  held PC and PC+2
- out_ir  out  IR_W  held instruction, or NOP when out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Storage:
  - main entry drives the outputs
  - skid entry is used only when main is held
- States:
  - EMPTY: main invalid
  - BUSY: main valid, skid invalid
  - FULL: both valid
- in_ready = (state != FULL), a function of registered state only. There is no path from out_ready.
- An accept occurs when in_valid & in_ready. A consume occurs when out_valid & out_ready.
- Transitions (no flush):
  - EMPTY: accept -> BUSY (main <= input); otherwise stay.
  - BUSY, accept & consume -> BUSY (main <= input).
  - BUSY, accept & !consume -> FULL (skid <= input).
  - BUSY, !accept & consume -> EMPTY.
  - BUSY, neither -> hold.
  - FULL: consume -> BUSY (main <= skid); otherwise hold. No accept is possible.
- flush has priority over everything:
  - next state is EMPTY
  - any accept in the same cycle is discarded
  - held pc/pc2 may keep stale values, but out_ir = NOP and out_valid = 0 next cycle
- out_ir = NOP whenever out_valid = 0. out_pc and out_pc2 hold their last value when invalid.
- stall_cnt increments by 1 each cycle out_valid & !out_ready and saturates at all-ones. It is cleared only by reset and is not cleared by flush.
- Reset (rst = 0 at an edge):
  - state EMPTY, out_valid 0, out_pc/out_pc2 0, out_ir NOP, stall_cnt 0
  - in_ready reads 1 from the first cycle after reset
  - reset overrides flush and any in-flight handshake

## Timing
- Latency: an entry accepted at edge N appears on the outputs after edge N, so it is visible during cycle N+1.
- Throughput: one entry per cycle when out_ready is held high.
- Skid behaviour: if out_ready drops while in_valid is high, the entry in flight is captured in skid. in_ready drops one cycle later and no data is lost.
- FULL to BUSY: the skid entry appears on the outputs the cycle after the consume.
- in_ready rises again in that same cycle.
- Flush to first accept: a fetch may be accepted in the cycle immediately after the flush edge.
- Simultaneous flush and consume: the consume completes for decode, and the state still goes to EMPTY.

## Structure
- A shared pipeline package holds:
  - the state encoding (EMPTY/BUSY/FULL as a 2-bit enum/localparams)
  - the default NOP constant
- One sub-module, pipe_entry_reg: a PC_W/PC_W/IR_W register with load enable, instantiated twice (main, skid).
- Control FSM and stall counter live in the top module.

## Test plan
- Reset, then in_valid=1 with pc=0x0010, pc2=0x0012, ir=0x1234, out_ready=1. Required: out_valid=1, out_ir=0x1234 one cycle later, with one entry per cycle thereafter.
- Streaming with out_ready=0 for 3 cycles. Required:
  - second entry (pc=0x0014) held in skid
  - in_ready=0 from the next cycle
  - out_ready=1 then yields 0x0010 followed by 0x0014, in order, nothing dropped
  - stall_cnt=3
- FULL state with flush=1 and in_valid=1 (ir=0xBEEF). Required: next cycle out_valid=0, out_ir=NOP, in_ready=1, and 0xBEEF never appears.
- With CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles. Required: stall_cnt=0xF and stays there.
- rst=0 asserted mid-stream in FULL. Required: next cycle out_valid=0, out_pc=0, out_ir=NOP, stall_cnt=0, and in_ready=1 after release.
- Random in_valid/out_ready/flush over 10k cycles against a reference queue model. Required:
  - order preserved
  - no duplication
  - no loss except entries discarded by flush

Source files
------------

// File: rtl/if_id_skid_pkg.sv
// -----------------------------------------------------------------------------
// if_id_skid_pkg
// Shared definitions for the fetch/decode boundary register:
//   - pipe_state_e      : occupancy state of the two-entry skid register
//   - PIPE_NOP_DEFAULT  : instruction word shown to decode when nothing is valid
// -----------------------------------------------------------------------------
package if_id_skid_pkg;

    // EMPTY: main invalid; BUSY: main valid, skid invalid; FULL: both valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } pipe_state_e;

    localparam int PIPE_IR_W_DEFAULT = 16;

    // All-zero instruction word used as the bubble presented to decode.
    localparam logic [PIPE_IR_W_DEFAULT-1:0] PIPE_NOP_DEFAULT = '0;

endpackage

// File: rtl/if_id_skid_pipe_entry_reg.sv
// -----------------------------------------------------------------------------
// pipe_entry_reg
// One fetch/decode entry (PC, PC+2, instruction) held in a load-enabled
// register. Used twice by if_id_skid: once as the main entry, once as skid.
//
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous active-low reset, clears all fields to zero
//   load_i  : capture pc_i/pc2_i/ir_i on this edge
//   pc_i, pc2_i, ir_i : entry to capture
//   pc_o, pc2_o, ir_o : currently held entry
// -----------------------------------------------------------------------------
module pipe_entry_reg #(
    parameter int PC_W = 16,
    parameter int IR_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] pc2_i,
    input  logic [IR_W-1:0] ir_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc2_o,
    output logic [IR_W-1:0] ir_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc2_q;
    logic [IR_W-1:0] ir_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q  <= '0;
            pc2_q <= '0;
            ir_q  <= '0;
        end else if (load_i) begin
            pc_q  <= pc_i;
            pc2_q <= pc2_i;
            ir_q  <= ir_i;
        end
    end

    assign pc_o  = pc_q;
    assign pc2_o = pc2_q;
    assign ir_o  = ir_q;

endmodule

// File: rtl/if_id_skid.sv
// -----------------------------------------------------------------------------
// if_id_skid
// Fetch/decode boundary register with valid/ready handshake and a two-entry
// skid buffer. in_ready depends only on registered state, so decode stalls
// never propagate combinationally back into fetch; the one entry already in
// flight when decode stalls is parked in the skid entry.
//
// Ports:
//   clk               : clock, rising edge
//   rst               : synchronous active-low reset (overrides everything)
//   flush             : taken branch, discards held and incoming entries
//   in_valid/in_ready : fetch-side handshake
//   in_pc, in_pc2, in_ir : fetch-side entry
//   out_valid/out_ready  : decode-side handshake
//   out_pc, out_pc2, out_ir : decode-side entry (out_ir = NOP when invalid)
//   stall_cnt         : saturating count of cycles with out_valid & !out_ready
// -----------------------------------------------------------------------------
module if_id_skid
    import if_id_skid_pkg::*;
#(
    parameter int              PC_W  = 16,
    parameter int              IR_W  = 16,
    parameter logic [IR_W-1:0] NOP   = IR_W'(PIPE_NOP_DEFAULT),
    parameter int              CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [PC_W-1:0]  in_pc2,
    input  logic [IR_W-1:0]  in_ir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [PC_W-1:0]  out_pc2,
    output logic [IR_W-1:0]  out_ir,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_e      state_q, state_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             consume;
    logic             main_load;
    logic             skid_load;
    logic             main_from_skid;

    logic [PC_W-1:0]  main_pc_d, main_pc2_d;
    logic [IR_W-1:0]  main_ir_d;
    logic [PC_W-1:0]  main_pc, main_pc2;
    logic [IR_W-1:0]  main_ir;
    logic [PC_W-1:0]  skid_pc, skid_pc2;
    logic [IR_W-1:0]  skid_ir;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign accept  = in_valid & in_ready_q;
    assign consume = out_valid_q & out_ready;

    // Next-state and entry load decisions. flush wins over any handshake,
    // so no entry is loaded on a flush edge (pc fields may stay stale).
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_BUSY;
                        main_load = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_FULL;
                        skid_load = 1'b1;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a consume can move us.
                    if (consume) begin
                        state_d        = ST_BUSY;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        main_pc_d  = main_from_skid ? skid_pc  : in_pc;
        main_pc2_d = main_from_skid ? skid_pc2 : in_pc2;
        main_ir_d  = main_from_skid ? skid_ir  : in_ir;
    end

    // Stall counter keeps counting through flushes; only reset clears it.
    assign cnt_d = (out_valid_q && !out_ready) ? sat_inc(cnt_q) : cnt_q;

    // Control registers: handshake outputs are registered from state_d so
    // they always agree with state_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
            cnt_q       <= cnt_d;
        end
    end

    pipe_entry_reg #(.PC_W(PC_W), .IR_W(IR_W)) u_main (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (main_load),
        .pc_i   (main_pc_d),
        .pc2_i  (main_pc2_d),
        .ir_i   (main_ir_d),
        .pc_o   (main_pc),
        .pc2_o  (main_pc2),
        .ir_o   (main_ir)
    );

    pipe_entry_reg #(.PC_W(PC_W), .IR_W(IR_W)) u_skid (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (skid_load),
        .pc_i   (in_pc),
        .pc2_i  (in_pc2),
        .ir_i   (in_ir),
        .pc_o   (skid_pc),
        .pc2_o  (skid_pc2),
        .ir_o   (skid_ir)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pc    = main_pc;
    assign out_pc2   = main_pc2;
    assign out_ir    = out_valid_q ? main_ir : NOP;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_if_id_skid.sv
module tb_if_id_skid;

    localparam logic [15:0] TB_NOP = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_pc, in_pc2, in_ir;
    logic        out_ready;

    logic        in_ready, out_valid;
    logic [15:0] out_pc, out_pc2, out_ir, stall_cnt;

    logic        b_in_ready, b_out_valid;
    logic [15:0] b_out_pc, b_out_pc2, b_out_ir;
    logic [3:0]  b_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_id_skid #(.PC_W(16), .IR_W(16), .NOP(TB_NOP), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_pc2(in_pc2), .in_ir(in_ir),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pc2(out_pc2), .out_ir(out_ir),
        .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance, shares stimulus; used for saturation checks.
    if_id_skid #(.PC_W(16), .IR_W(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_pc(in_pc), .in_pc2(in_pc2), .in_ir(in_ir),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_out_pc), .out_pc2(b_out_pc2), .out_ir(b_out_ir),
        .stall_cnt(b_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] ir,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_pc2    = pc + 16'd2;
        in_ir     = ir;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 16'h7777, 16'h7777, 1'b1, 1'b1);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        checks++; if (out_pc !== 16'h0) begin errors++; $display("FAIL rst_pc got %h exp 0000", out_pc); end
        checks++; if (out_pc2 !== 16'h0) begin errors++; $display("FAIL rst_pc2 got %h exp 0000", out_pc2); end
        checks++; if (out_ir !== TB_NOP) begin errors++; $display("FAIL rst_ir got %h exp %h", out_ir, TB_NOP); end
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt got %h exp 0", stall_cnt); end
        checks++; if (b_stall_cnt !== 4'h0) begin errors++; $display("FAIL rst_cnt4 got %h exp 0", b_stall_cnt); end
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_stream();
        logic [15:0] exp_ir, exp_pc;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            exp_pc = 16'h0010 + 16'(4 * i);
            exp_ir = 16'h1234 + 16'(i);
            drive(1'b1, exp_pc, exp_ir, 1'b1, 1'b0);
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, out_valid); end
            checks++; if (out_ir !== exp_ir) begin errors++; $display("FAIL stream_ir[%0d] got %h exp %h", i, out_ir, exp_ir); end
            checks++; if (out_pc !== exp_pc || out_pc2 !== exp_pc + 16'd2) begin errors++; $display("FAIL stream_pc[%0d] got %h/%h exp %h", i, out_pc, out_pc2, exp_pc); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready); end
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b0 || out_ir !== TB_NOP) begin errors++; $display("FAIL stream_drain got %b/%h exp 0/%h", out_valid, out_ir, TB_NOP); end
    endtask

    task automatic test_skid();
        apply_reset();
        drive(1'b1, 16'h0010, 16'h1234, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h0014, 16'h1238, 1'b0, 1'b0);
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_in_ready got %b exp 0", in_ready); end
        checks++; if (out_ir !== 16'h1234) begin errors++; $display("FAIL skid_hold_ir got %h exp 1234", out_ir); end
        drive(1'b1, 16'h0018, 16'hCCCC, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL skid_cnt got %0d exp 3", stall_cnt); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0010) begin errors++; $display("FAIL skid_first got %b/%h exp 1/0010", out_valid, out_pc); end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0014 || out_ir !== 16'h1238) begin errors++; $display("FAIL skid_second got %b/%h/%h exp 1/0014/1238", out_valid, out_pc, out_ir); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_back got %b exp 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_ir !== TB_NOP) begin errors++; $display("FAIL skid_empty got %b/%h exp 0/%h", out_valid, out_ir, TB_NOP); end
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL skid_cnt_final got %0d exp 3", stall_cnt); end
    endtask

    task automatic test_flush();
        apply_reset();
        drive(1'b1, 16'h0020, 16'h1111, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0024, 16'h2222, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0028, 16'hBEEF, 1'b0, 1'b1);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
        checks++; if (out_ir !== TB_NOP) begin errors++; $display("FAIL flush_ir got %h exp %h", out_ir, TB_NOP); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
        drive(1'b1, 16'h0100, 16'h3333, 1'b0, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_ir !== 16'h3333) begin errors++; $display("FAIL flush_next_accept got %b/%h exp 1/3333", out_valid, out_ir); end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_ir === 16'hBEEF) begin errors++; $display("FAIL flush_leak[%0d] got %h exp not BEEF", i, out_ir); end
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        drive(1'b1, 16'h0040, 16'h4444, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 14) begin
                checks++; if (b_stall_cnt !== 4'hE) begin errors++; $display("FAIL sat_mid got %h exp e", b_stall_cnt); end
            end
            if (k >= 15) begin
                checks++; if (b_stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_cnt[%0d] got %h exp f", k, b_stall_cnt); end
            end
        end
        checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_wide_cnt got %0d exp 20", stall_cnt); end
        checks++; if (b_out_valid !== 1'b1 || b_out_ir !== 16'h4444) begin errors++; $display("FAIL sat_hold got %b/%h exp 1/4444", b_out_valid, b_out_ir); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(1'b1, 16'h0050, 16'h5555, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0054, 16'h5656, 1'b0, 1'b0);
        tick();
        checks++; if (in_ready !== 1'b0 || stall_cnt !== 16'd1) begin errors++; $display("FAIL mid_full got %b/%0d exp 0/1", in_ready, stall_cnt); end
        rst = 1'b0;
        drive(1'b1, 16'h0058, 16'h5757, 1'b1, 1'b1);
        tick();
        checks++; if (out_valid !== 1'b0 || out_pc !== 16'h0 || out_pc2 !== 16'h0) begin errors++; $display("FAIL mid_rst_entry got %b/%h/%h exp 0/0000/0000", out_valid, out_pc, out_pc2); end
        checks++; if (out_ir !== TB_NOP || stall_cnt !== 16'h0) begin errors++; $display("FAIL mid_rst_ir_cnt got %h/%0d exp %h/0", out_ir, stall_cnt, TB_NOP); end
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_release got %b/%b exp 1/0", in_ready, out_valid); end
    endtask

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ir;
    } ent_t;

    task automatic test_random();
        ent_t        q[$];
        ent_t        e;
        int          cnt_model = 0;
        logic [15:0] seq = 16'd1;
        logic        v, ordy, fl;
        logic [15:0] ir;
        bit          acc, cons;
        apply_reset();
        for (int c = 0; c < 10000; c++) begin
            checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %0d", c, out_valid, q.size() > 0); end
            checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %0d", c, in_ready, q.size() < 2); end
            if (q.size() > 0) begin
                checks++;
                if (out_ir !== q[0].ir || out_pc !== q[0].pc || out_pc2 !== q[0].pc + 16'd2) begin
                    errors++; $display("FAIL rnd_entry[%0d] got %h/%h/%h exp %h/%h", c, out_pc, out_pc2, out_ir, q[0].pc, q[0].ir);
                end
            end else begin
                checks++; if (out_ir !== TB_NOP) begin errors++; $display("FAIL rnd_nop[%0d] got %h exp %h", c, out_ir, TB_NOP); end
            end
            checks++; if (stall_cnt !== 16'(cnt_model)) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", c, stall_cnt, cnt_model); end

            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            ir   = 16'($urandom);
            drive(v, seq, ir, ordy, fl);

            if (q.size() > 0 && !ordy && cnt_model < 65535) cnt_model++;
            acc  = v && (q.size() < 2);
            cons = (q.size() > 0) && ordy;
            if (fl) begin
                q.delete();
            end else begin
                if (cons) void'(q.pop_front());
                if (acc) begin
                    e.pc = seq;
                    e.ir = ir;
                    q.push_back(e);
                end
            end
            seq = seq + 16'd4;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
